// File: rtl/sc_ifetch.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake and presents the IR for one commit cycle.
// Optional misaligned-target trap (addr_err + HALT) is enabled by defining IFETCH_ALIGN_CHECK_EN.
module sc_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_w;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign pc4_w  = pc_q + 32'd4;
    assign br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc4_w;
        case (pcsource)
            2'b00: next_pc = pc4_w;
            2'b01: next_pc = pc4_w + br_off;
            2'b10: next_pc = ra_data;
            2'b11: next_pc = {pc4_w[31:28], inst_q[25:0], 2'b00};
            default: next_pc = pc4_w;
        endcase
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic addr_err_q, addr_err_d;
    logic misaligned;

    assign misaligned = (next_pc[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        addr_err_d = addr_err_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ack) begin
                       inst_d  = imem_rdata;
                       state_d = EXEC;
                   end
            EXEC:  begin
                       // Target is loaded even when misaligned so the faulting PC is visible.
                       pc_d = next_pc;
                       if (misaligned) begin
                           addr_err_d = 1'b1;
                           state_d    = HALT;
                       end else begin
                           state_d = FETCH;
                       end
                   end
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_err_q <= 1'b0;
        else     addr_err_q <= addr_err_d;
    end

    assign addr_err = addr_err_q;
`else
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ack) begin
                       inst_d  = imem_rdata;
                       state_d = EXEC;
                   end
            EXEC:  begin
                       // Misaligned targets are silently word-aligned.
                       pc_d    = next_pc & ~32'd3;
                       state_d = FETCH;
                   end
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == EXEC);
    assign inst       = inst_q;
    assign op         = inst_q[31:26];
    assign func       = inst_q[5:0];
    assign pc         = pc_q;
    assign pc4        = pc4_w;

endmodule

// File: tb/tb_sc_ifetch.sv
// Table-driven bench for sc_ifetch: the bench plays instruction memory and control unit.
module tb_sc_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] ra_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        addr_err;

    sc_ifetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pcsource(pcsource), .ra_data(ra_data),
        .inst_valid(inst_valid), .inst(inst), .op(op), .func(func),
        .pc(pc), .pc4(pc4), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  psrc;
        logic [31:0] ra;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [31:0] pc4;
    } vec_t;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam int NVEC = 13;
`else
    localparam int NVEC = 14;
`endif

    vec_t vecs[14];
    int   npass = 0;
    int   ntotal = 0;
    int   last_exec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic do_instr(input vec_t v, input bit chk_cpi);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, v.addr);
        for (int i = 0; i < v.waits; i++) begin
            imem_ack = 1'b0;
            imem_rdata = 32'hBAD0_0000 | i;
            @(negedge clk);
            chk("wait_req_held", {31'b0, imem_req}, 32'd1);
            chk("wait_addr_stable", imem_addr, v.addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        pcsource   = v.psrc;
        ra_data    = v.ra;
        @(negedge clk);
        // stale ack with garbage during EXEC must not touch the IR
        imem_ack   = 1'b1;
        imem_rdata = ~v.rdata;
        chk("exec_valid", {31'b0, inst_valid}, 32'd1);
        chk("exec_req_low", {31'b0, imem_req}, 32'd0);
        chk("exec_inst", inst, v.rdata);
        chk("exec_op", {26'b0, op}, {26'b0, v.op});
        chk("exec_func", {26'b0, func}, {26'b0, v.func});
        chk("exec_pc", pc, v.addr);
        chk("exec_pc4", pc4, v.pc4);
        chk("exec_addr_err", {31'b0, addr_err}, 32'd0);
        if (chk_cpi) chk("cycles_per_instr", cyc - last_exec, 2 + v.waits);
        last_exec = cyc;
        @(negedge clk);
        imem_ack   = 1'b0;
        pcsource   = 2'b11;
        ra_data    = 32'hFFFF_FFFF;
        chk("post_exec_valid_low", {31'b0, inst_valid}, 32'd0);
        chk("post_exec_inst_kept", inst, v.rdata);
    endtask

    initial begin
        vec_t v0;
        vecs[0]  = '{32'h0000_0000, 32'h2001_0005, 0, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0004, 32'h2001_0005, 0, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0008, 32'h2001_0005, 0, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_000C};
        vecs[3]  = '{32'h0000_000C, 32'h2001_0005, 3, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_0010};
        vecs[4]  = '{32'h0000_0010, 32'h1000_FFFE, 3, 2'b00, 32'h0,         6'h04, 6'h3E, 32'h0000_0014};
        vecs[5]  = '{32'h0000_0014, 32'h0000_0008, 0, 2'b10, 32'h0000_0010, 6'h00, 6'h08, 32'h0000_0018};
        vecs[6]  = '{32'h0000_0010, 32'h1000_FFFE, 0, 2'b01, 32'h0,         6'h04, 6'h3E, 32'h0000_0014};
        vecs[7]  = '{32'h0000_000C, 32'h0000_0008, 1, 2'b10, 32'h3000_0000, 6'h00, 6'h08, 32'h0000_0010};
        vecs[8]  = '{32'h3000_0000, 32'h0C00_0040, 0, 2'b11, 32'h0,         6'h03, 6'h00, 32'h3000_0004};
        vecs[9]  = '{32'h3000_0100, 32'h0000_0008, 2, 2'b10, 32'hFFFF_FFFC, 6'h00, 6'h08, 32'h3000_0104};
        vecs[10] = '{32'hFFFF_FFFC, 32'h2001_0005, 0, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_0000};
        vecs[11] = '{32'h0000_0000, 32'h2001_0005, 0, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_0004};
        vecs[12] = '{32'h0000_0004, 32'h0000_0008, 0, 2'b10, 32'h0000_0102, 6'h00, 6'h08, 32'h0000_0008};
        vecs[13] = '{32'h0000_0100, 32'h2001_0005, 0, 2'b00, 32'h0,         6'h08, 6'h05, 32'h0000_0104};

        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        rst = 1'b0;
        #1 chk("idle_bubble_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) do_instr(vecs[i], i > 0);

`ifdef IFETCH_ALIGN_CHECK_EN
        chk("halt_addr_err", {31'b0, addr_err}, 32'd1);
        chk("halt_pc_loaded", pc, 32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            chk("halt_req_low", {31'b0, imem_req}, 32'd0);
            chk("halt_valid_low", {31'b0, inst_valid}, 32'd0);
        end
        imem_ack = 1'b0;
        chk("halt_addr_err_sticky", {31'b0, addr_err}, 32'd1);
        rst = 1'b1;
        #1 chk("halt_rst_clears_err", {31'b0, addr_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        chk("midfetch_req_before_rst", {31'b0, imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midfetch_rst_req", {31'b0, imem_req}, 32'd0);
        chk("midfetch_rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("midfetch_rst_pc", pc, 32'h0);
        chk("midfetch_rst_inst", inst, 32'h0);
        chk("midfetch_rst_addr_err", {31'b0, addr_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1 chk("stale_ack_idle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stale_ack_ignored", inst, 32'h0);
        chk("refetch_req", {31'b0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
        v0 = vecs[0];
        do_instr(v0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
